// File: rtl/e203_reset_req_gen.sv
// Reset-source aggregator/stretcher: merges pad reset with wdg/ndm/sw requests into one stretched sys_rst_n.
// Optional E203_RESET_REQ_DBG_MASK_EN adds dbg_mode, which drops watchdog edges while high.
module e203_reset_req_gen #(
   parameter int unsigned SYNC_LEVEL   = 2,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned HOLD_CYCLES  = 16,
   parameter int unsigned GUARD_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       test_mode,
   input  logic       wdg_rst_req,
   input  logic       ndm_rst_req,
   input  logic       sw_rst_req,
`ifdef E203_RESET_REQ_DBG_MASK_EN
   input  logic       dbg_mode,
`endif
   input  logic       cause_clr,
   output logic       sys_rst_n,
   output logic [3:0] rst_cause,
   output logic       rst_busy
);

   localparam int unsigned NREQ = 3;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      GUARD  = 2'd2
   } state_t;

   state_t                         state;
   logic [CNT_W-1:0]               cnt;
   logic                           pend;
   logic                           sys_q;
   logic [SYNC_LEVEL-1:0][NREQ-1:0] sync;
   logic [NREQ-1:0]                sync_dly;
   logic [NREQ-1:0]                edge_raw;
   logic [NREQ-1:0]                req_edge;
   logic                           any_edge;

   // Request synchronizers plus one delayed copy for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync     <= '0;
         sync_dly <= '0;
      end else begin
         sync     <= {sync[SYNC_LEVEL-2:0], {sw_rst_req, ndm_rst_req, wdg_rst_req}};
         sync_dly <= sync[SYNC_LEVEL-1];
      end
   end

   assign edge_raw = sync[SYNC_LEVEL-1] & ~sync_dly;

`ifdef E203_RESET_REQ_DBG_MASK_EN
   assign req_edge = edge_raw & {2'b11, ~dbg_mode};
`else
   assign req_edge = edge_raw;
`endif

   assign any_edge = |req_edge;

   // Hold/guard sequencer; sys_q and rst_busy are registered with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ASSERT;
         cnt      <= '0;
         pend     <= 1'b0;
         sys_q    <= 1'b0;
         rst_busy <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (any_edge) begin
                  state    <= ASSERT;
                  cnt      <= '0;
                  sys_q    <= 1'b0;
                  rst_busy <= 1'b1;
               end else begin
                  sys_q    <= 1'b1;
                  rst_busy <= 1'b0;
               end
            end
            ASSERT: begin
               rst_busy <= 1'b1;
               if (cnt == HOLD_LAST) begin
                  state <= GUARD;
                  cnt   <= '0;
                  sys_q <= 1'b1;
               end else begin
                  cnt   <= cnt + CNT_W'(1);
                  sys_q <= 1'b0;
               end
            end
            GUARD: begin
               if (cnt == GUARD_LAST) begin
                  cnt  <= '0;
                  pend <= 1'b0;
                  if (pend || any_edge) begin
                     state    <= ASSERT;
                     sys_q    <= 1'b0;
                     rst_busy <= 1'b1;
                  end else begin
                     state    <= IDLE;
                     sys_q    <= 1'b1;
                     rst_busy <= 1'b0;
                  end
               end else begin
                  cnt      <= cnt + CNT_W'(1);
                  sys_q    <= 1'b1;
                  rst_busy <= 1'b1;
                  if (any_edge) pend <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               pend     <= 1'b0;
               sys_q    <= 1'b1;
               rst_busy <= 1'b0;
            end
         endcase
      end
   end

   // Sticky cause flags; a same-cycle edge survives cause_clr for its own bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cause <= 4'b0001;
      end else begin
         rst_cause <= (cause_clr ? 4'b0000 : rst_cause) | {req_edge, 1'b0};
      end
   end

   assign sys_rst_n = test_mode ? rst_n : sys_q;

endmodule

// File: tb/tb_e203_reset_req_gen.sv
// Directed bench for e203_reset_req_gen: table of single-request events plus hand-written corner sequences.
module tb_e203_reset_req_gen;

   logic       clk = 1'b0;
   logic       rst_n, test_mode, wdg, ndm, sw, clr;
   logic       dbg_mode;
   logic       sys_rst_n, rst_busy;
   logic [3:0] rst_cause;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   e203_reset_req_gen dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .test_mode   (test_mode),
      .wdg_rst_req (wdg),
      .ndm_rst_req (ndm),
      .sw_rst_req  (sw),
`ifdef E203_RESET_REQ_DBG_MASK_EN
      .dbg_mode    (dbg_mode),
`endif
      .cause_clr   (clr),
      .sys_rst_n   (sys_rst_n),
      .rst_cause   (rst_cause),
      .rst_busy    (rst_busy)
   );

   typedef struct {
      logic [2:0] req;       // {sw, ndm, wdg}
      int         hold;
      int         clr_at;
      bit         do_rst;
      logic [3:0] exp_cause;
      int         exp_first;
      int         exp_low;
      int         exp_busy;
   } vec_t;

   vec_t tbl[4];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
      end
   endtask

   task automatic drive(input logic [2:0] r, input logic c);
      {sw, ndm, wdg} = r;
      clr = c;
   endtask

   // Called at a negedge; sample index j = posedges since the first drive.
   task automatic run_window(input int n, input logic [2:0] ra, input int hold_a,
                             input logic [2:0] rb, input int start_b, input int len_b,
                             input int clr_at, output int first_low, output int low,
                             output int busy);
      first_low = -1;
      low = 0;
      busy = 0;
      for (int j = 0; j <= n; j++) begin
         if (j > 0) @(negedge clk);
         if (sys_rst_n === 1'b0) begin
            low++;
            if (first_low < 0) first_low = j;
         end
         if (rst_busy === 1'b1) busy++;
         drive(((j < hold_a) ? ra : 3'b000) |
               ((j >= start_b && j < start_b + len_b) ? rb : 3'b000), (j == clr_at));
      end
      drive(3'b000, 1'b0);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (rst_busy !== 1'b0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) check("idle_timeout", 32'(rst_busy), 32'd0);
   endtask

   task automatic mid_reset();
      int f, l, b;
      drive(3'b010, 1'b0);
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         if (j == 2) drive(3'b000, 1'b0);
      end
      check("mid_in_assert", 32'(sys_rst_n), 32'd0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_cause", 32'(rst_cause), 32'd1);
      check("mid_rst_busy", 32'(rst_busy), 32'd1);
      check("mid_rst_sys", 32'(sys_rst_n), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_window(40, 3'b000, 0, 3'b000, 0, 0, -1, f, l, b);
      check("mid_restart_low", 32'(l), 32'd16);
      check("mid_restart_busy", 32'(b), 32'd24);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int f, l, b;
      rst_n = 1'b0;
      test_mode = 1'b0;
      dbg_mode = 1'b0;
      drive(3'b000, 1'b0);

      tbl[0] = '{3'b001,   3, -1, 1'b0, 4'b0011, 3, 16, 24};
      tbl[1] = '{3'b001, 100, -1, 1'b0, 4'b0011, 3, 16, 24};
      tbl[2] = '{3'b010,   3,  2, 1'b0, 4'b0100, 3, 16, 24};
      tbl[3] = '{3'b110,   3, -1, 1'b1, 4'b1101, 3, 16, 24};

      // Power-on.
      repeat (3) @(negedge clk);
      check("por_sys", 32'(sys_rst_n), 32'd0);
      check("por_busy", 32'(rst_busy), 32'd1);
      check("por_cause", 32'(rst_cause), 32'd1);
      rst_n = 1'b1;
      run_window(40, 3'b000, 0, 3'b000, 0, 0, -1, f, l, b);
      check("por_low_len", 32'(l), 32'd16);
      check("por_busy_len", 32'(b), 32'd24);
      check("por_cause_after", 32'(rst_cause), 32'd1);

      // Single-event table.
      for (int i = 0; i < 4; i++) begin
         wait_idle();
         if (tbl[i].do_rst) begin
            mid_reset();
            wait_idle();
         end
         run_window(tbl[i].hold + 40, tbl[i].req, tbl[i].hold, 3'b000, 0, 0, tbl[i].clr_at,
                    f, l, b);
         check($sformatf("row%0d_first_low", i), 32'(f), 32'(tbl[i].exp_first));
         check($sformatf("row%0d_low_len", i), 32'(l), 32'(tbl[i].exp_low));
         check($sformatf("row%0d_busy_len", i), 32'(b), 32'(tbl[i].exp_busy));
         check($sformatf("row%0d_cause", i), 32'(rst_cause), 32'(tbl[i].exp_cause));
      end

      // Edge during GUARD is pended and chains straight into a second window.
      wait_idle();
      run_window(70, 3'b001, 3, 3'b100, 20, 3, -1, f, l, b);
      check("pend_first_low", 32'(f), 32'd3);
      check("pend_low_len", 32'(l), 32'd32);
      check("pend_busy_len", 32'(b), 32'd48);
      check("pend_cause", 32'(rst_cause), 32'hf);

      // Plain clear.
      wait_idle();
      drive(3'b000, 1'b1);
      @(negedge clk);
      drive(3'b000, 1'b0);
      check("clr_cause", 32'(rst_cause), 32'd0);

      // DFT bypass.
      test_mode = 1'b1;
      rst_n = 1'b0;
      #1;
      check("tm_sys_low", 32'(sys_rst_n), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("tm_sys_follow", 32'(sys_rst_n), 32'd1);
      @(negedge clk);
      wait_idle();
      run_window(45, 3'b001, 3, 3'b000, 0, 0, -1, f, l, b);
      check("tm_low_len", 32'(l), 32'd0);
      check("tm_busy_len", 32'(b), 32'd24);
      check("tm_cause", 32'(rst_cause), 32'd3);
      test_mode = 1'b0;
      #1;
      check("tm_off_sys", 32'(sys_rst_n), 32'd1);
      @(negedge clk);

`ifdef E203_RESET_REQ_DBG_MASK_EN
      // Masked watchdog edge is dropped entirely.
      wait_idle();
      drive(3'b000, 1'b1);
      @(negedge clk);
      drive(3'b000, 1'b0);
      dbg_mode = 1'b1;
      run_window(40, 3'b001, 3, 3'b000, 0, 0, -1, f, l, b);
      check("dbg_low_len", 32'(l), 32'd0);
      check("dbg_busy_len", 32'(b), 32'd0);
      check("dbg_cause", 32'(rst_cause), 32'd0);
      dbg_mode = 1'b0;
      run_window(40, 3'b010, 3, 3'b000, 0, 0, -1, f, l, b);
      check("dbg_ndm_low_len", 32'(l), 32'd16);
      check("dbg_ndm_cause", 32'(rst_cause), 32'd4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
